// File: rtl/dm_lsu.sv
// Load/store unit between the memory stage and the word-organised data memory dm.
// Optional feature: define LSU_MISALIGN_TRAP_EN to fault misaligned half/word requests.
module dm_lsu #(
    parameter int data_size    = 32,
    parameter int mem_size_bit = 12
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    req_valid,
    output logic                    req_ready,
    input  logic                    req_write,
    input  logic [1:0]              req_size,
    input  logic                    req_unsigned,
    input  logic [mem_size_bit-1:0] req_address,
    input  logic [data_size-1:0]    req_wdata,
    output logic                    resp_valid,
    output logic [data_size-1:0]    resp_rdata,
    output logic                    resp_fault,
    output logic                    DM_enable,
    output logic                    DM_read,
    output logic                    DM_write,
    output logic [mem_size_bit-1:0] DM_address,
    output logic [data_size-1:0]    DMin,
    input  logic [data_size-1:0]    DMout
);

    // state | meaning
    // IDLE  | ready for a request; response pulse is presented here
    // RD    | dm read strobe (load, or first half of a sub-word store)
    // CAP   | DMout valid: extract load data or merge store lane
    // WR    | dm write strobe with the full word in DMin
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RD   = 2'd1,
        S_CAP  = 2'd2,
        S_WR   = 2'd3
    } state_t;

    state_t r_state;
    state_t w_next;

    logic                    r_write;
    logic [1:0]              r_size;
    logic                    r_unsigned;
    logic [1:0]              r_lane;
    logic [mem_size_bit-1:0] r_addr;
    logic [data_size-1:0]    r_wdata;
    logic                    r_resp_valid;
    logic [data_size-1:0]    r_resp_rdata;

    logic                    w_done;
    logic                    w_misalign;
    logic [7:0]              w_byte;
    logic [15:0]             w_half;
    logic [data_size-1:0]    w_load;
    logic [data_size-1:0]    w_merged;

`ifdef LSU_MISALIGN_TRAP_EN
    logic r_resp_fault;

    assign w_misalign = ((req_size == 2'b01) && req_address[0]) ||
                        (req_size[1] && (req_address[1:0] != 2'b00));

    always_ff @(posedge clock) begin
        if (reset) begin
            r_resp_fault <= 1'b0;
        end else if ((r_state == S_IDLE) && req_valid) begin
            r_resp_fault <= w_misalign;
        end
    end

    assign resp_fault = r_resp_fault;
`else
    assign w_misalign = 1'b0;
    assign resp_fault = 1'b0;
`endif

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next    = r_state;
        req_ready = 1'b0;
        DM_enable = 1'b0;
        DM_read   = 1'b0;
        DM_write  = 1'b0;
        w_done    = 1'b0;
        case (r_state)
            S_IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    if (w_misalign) begin
                        w_done = 1'b1;
                    end else if (req_write && req_size[1]) begin
                        w_next = S_WR;
                    end else begin
                        w_next = S_RD;
                    end
                end
            end
            S_RD: begin
                DM_enable = 1'b1;
                DM_read   = 1'b1;
                w_next    = S_CAP;
            end
            S_CAP: begin
                if (r_write) begin
                    w_next = S_WR;
                end else begin
                    w_next = S_IDLE;
                    w_done = 1'b1;
                end
            end
            S_WR: begin
                DM_enable = 1'b1;
                DM_write  = 1'b1;
                w_next    = S_IDLE;
                w_done    = 1'b1;
            end
            default: w_next = S_IDLE;
        endcase
    end

    // Lane extraction and sign/zero extension of the returned word.
    always_comb begin
        case (r_lane)
            2'd0:    w_byte = DMout[7:0];
            2'd1:    w_byte = DMout[15:8];
            2'd2:    w_byte = DMout[23:16];
            default: w_byte = DMout[31:24];
        endcase
        w_half = r_lane[1] ? DMout[31:16] : DMout[15:0];
        case (r_size)
            2'b00:   w_load = {{(data_size-8){w_byte[7] & ~r_unsigned}}, w_byte};
            2'b01:   w_load = {{(data_size-16){w_half[15] & ~r_unsigned}}, w_half};
            default: w_load = DMout;
        endcase
    end

    // Read-modify-write merge: only the addressed lane takes store data.
    always_comb begin
        w_merged = DMout;
        case (r_size)
            2'b00: begin
                case (r_lane)
                    2'd0:    w_merged[7:0]   = r_wdata[7:0];
                    2'd1:    w_merged[15:8]  = r_wdata[7:0];
                    2'd2:    w_merged[23:16] = r_wdata[7:0];
                    default: w_merged[31:24] = r_wdata[7:0];
                endcase
            end
            2'b01: begin
                if (r_lane[1]) begin
                    w_merged[31:16] = r_wdata[15:0];
                end else begin
                    w_merged[15:0] = r_wdata[15:0];
                end
            end
            default: w_merged = r_wdata;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_write      <= 1'b0;
            r_size       <= 2'b00;
            r_unsigned   <= 1'b0;
            r_lane       <= 2'b00;
            r_addr       <= '0;
            r_wdata      <= '0;
            r_resp_valid <= 1'b0;
            r_resp_rdata <= '0;
        end else begin
            r_resp_valid <= w_done;
            case (r_state)
                S_IDLE: begin
                    if (req_valid) begin
                        r_write    <= req_write;
                        r_size     <= req_size;
                        r_unsigned <= req_unsigned;
                        r_lane     <= req_address[1:0];
                        r_addr     <= {req_address[mem_size_bit-1:2], 2'b00};
                        r_wdata    <= req_wdata;
                        if (w_misalign) begin
                            r_resp_rdata <= '0;
                        end
                    end
                end
                S_CAP: begin
                    if (r_write) begin
                        r_wdata <= w_merged;
                    end else begin
                        r_resp_rdata <= w_load;
                    end
                end
                S_WR: begin
                    r_resp_rdata <= '0;
                end
                default: ;
            endcase
        end
    end

    assign resp_valid = r_resp_valid;
    assign resp_rdata = r_resp_rdata;
    assign DM_address = r_addr;
    assign DMin       = r_wdata;

endmodule
